// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the MEM-stage FSM encoding.
package pipeline_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_REG_W  = 5;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } mem_state_e;

  localparam logic [DEF_REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/data_mem.sv
// Single-port synchronous data RAM with registered read data; contents are not reset.
module data_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: LW/SW against data_mem, ALU pass-through, two-cycle loads.
// Build option MEM_CONFLICT_CHECK_EN: simultaneous MemRead/MemWrite is dropped and flagged on mem_err.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EX_MEM_Valid,
  input  logic [DATA_W-1:0] EX_MEM_ALUResult,
  input  logic [DATA_W-1:0] EX_MEM_WriteData,
  input  logic [REG_W-1:0]  EX_MEM_Rd,
  input  logic              EX_MEM_MemRead,
  input  logic              EX_MEM_MemWrite,
  input  logic              EX_MEM_MemToReg,
  input  logic              EX_MEM_RegWrite,
  output logic              mem_stall,
  output logic              WB_RegWrite,
  output logic [REG_W-1:0]  WB_writeReg,
  output logic [DATA_W-1:0] WB_writeData,
  output logic              mem_err
);

  mem_state_e        state_q, state_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic [REG_W-1:0]  wb_write_reg_q, wb_write_reg_d;
  logic [DATA_W-1:0] wb_write_data_q, wb_write_data_d;
  logic [REG_W-1:0]  ld_rd_q, ld_rd_d;
  logic              ld_reg_write_q, ld_reg_write_d;
  logic              ld_mem_to_reg_q, ld_mem_to_reg_d;
  logic [DATA_W-1:0] ld_alu_q, ld_alu_d;

  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              rd_is_zero;

`ifdef MEM_CONFLICT_CHECK_EN
  logic mem_err_q, mem_err_d;
`endif

  assign rd_is_zero = (EX_MEM_Rd == REG_W'(REG_ZERO));

  data_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_data_mem (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (EX_MEM_ALUResult[ADDR_W-1:0]),
    .wdata(EX_MEM_WriteData),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d         = state_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_write_reg_d  = wb_write_reg_q;
    wb_write_data_d = wb_write_data_q;
    ld_rd_d         = ld_rd_q;
    ld_reg_write_d  = ld_reg_write_q;
    ld_mem_to_reg_d = ld_mem_to_reg_q;
    ld_alu_d        = ld_alu_q;
    ram_we          = 1'b0;
    ram_re          = 1'b0;
`ifdef MEM_CONFLICT_CHECK_EN
    mem_err_d       = mem_err_q;
`endif
    case (state_q)
      IDLE: begin
        wb_reg_write_d = 1'b0;
        if (EX_MEM_Valid) begin
          if (EX_MEM_MemRead && EX_MEM_MemWrite) begin
`ifdef MEM_CONFLICT_CHECK_EN
            mem_err_d = 1'b1;
`else
            ram_we = 1'b1;
`endif
          end else if (EX_MEM_MemWrite) begin
            ram_we = 1'b1;
          end else if (EX_MEM_MemRead) begin
            ram_re          = 1'b1;
            ld_rd_d         = EX_MEM_Rd;
            ld_reg_write_d  = EX_MEM_RegWrite && !rd_is_zero;
            ld_mem_to_reg_d = EX_MEM_MemToReg;
            ld_alu_d        = EX_MEM_ALUResult;
            state_d         = LOAD_WAIT;
          end else begin
            wb_write_data_d = EX_MEM_ALUResult;
            wb_write_reg_d  = EX_MEM_Rd;
            wb_reg_write_d  = EX_MEM_RegWrite && !rd_is_zero;
          end
        end
      end
      LOAD_WAIT: begin
        // EX/MEM is frozen by mem_stall; only the latched load fields matter here.
        wb_write_data_d = ld_mem_to_reg_q ? ram_rdata : ld_alu_q;
        wb_write_reg_d  = ld_rd_q;
        wb_reg_write_d  = ld_reg_write_q;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      wb_reg_write_q  <= 1'b0;
      wb_write_reg_q  <= '0;
      wb_write_data_q <= '0;
      ld_rd_q         <= '0;
      ld_reg_write_q  <= 1'b0;
      ld_mem_to_reg_q <= 1'b0;
      ld_alu_q        <= '0;
    end else begin
      state_q         <= state_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_write_reg_q  <= wb_write_reg_d;
      wb_write_data_q <= wb_write_data_d;
      ld_rd_q         <= ld_rd_d;
      ld_reg_write_q  <= ld_reg_write_d;
      ld_mem_to_reg_q <= ld_mem_to_reg_d;
      ld_alu_q        <= ld_alu_d;
    end
  end

`ifdef MEM_CONFLICT_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= mem_err_d;
    end
  end
  assign mem_err = mem_err_q;
`else
  assign mem_err = 1'b0;
`endif

  assign mem_stall    = (state_q == LOAD_WAIT);
  assign WB_RegWrite  = wb_reg_write_q;
  assign WB_writeReg  = wb_write_reg_q;
  assign WB_writeData = wb_write_data_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; conflict expectations follow MEM_CONFLICT_CHECK_EN.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_mr;
  logic        ex_mw;
  logic        ex_m2r;
  logic        ex_rw;
  logic        mem_stall;
  logic        wb_rw;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mem_err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

`ifdef MEM_CONFLICT_CHECK_EN
  localparam logic        EXP_ERR    = 1'b1;
  localparam logic [31:0] EXP_IDX4   = 32'hA5A5_A5A5;
`else
  localparam logic        EXP_ERR    = 1'b0;
  localparam logic [31:0] EXP_IDX4   = 32'h0000_0001;
`endif

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk             (clk),
    .rst             (rst),
    .EX_MEM_Valid    (ex_valid),
    .EX_MEM_ALUResult(ex_alu),
    .EX_MEM_WriteData(ex_wdata),
    .EX_MEM_Rd       (ex_rd),
    .EX_MEM_MemRead  (ex_mr),
    .EX_MEM_MemWrite (ex_mw),
    .EX_MEM_MemToReg (ex_m2r),
    .EX_MEM_RegWrite (ex_rw),
    .mem_stall       (mem_stall),
    .WB_RegWrite     (wb_rw),
    .WB_writeReg     (wb_reg),
    .WB_writeData    (wb_data),
    .mem_err         (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic mr, input logic mw,
                       input logic m2r, input logic rw);
    ex_valid = v;
    ex_alu   = alu;
    ex_wdata = wd;
    ex_rd    = rd;
    ex_mr    = mr;
    ex_mw    = mw;
    ex_m2r   = m2r;
    ex_rw    = rw;
  endtask

  task automatic bubble();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the next expected write-back value and checks the whole WB port.
  task automatic chk_wb(input string tag, input logic rw, input logic [4:0] rd);
    logic [31:0] exp_data;
    exp_data = exp_q.pop_front();
    chk({tag, "_rw"}, wb_rw, rw);
    chk({tag, "_reg"}, wb_reg, rd);
    chk({tag, "_data"}, wb_data, exp_data);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, mem_stall, 1'b0);
    chk({tag, "_rw"}, wb_rw, 1'b0);
    chk({tag, "_reg"}, wb_reg, 5'd0);
    chk({tag, "_data"}, wb_data, 32'h0);
    chk({tag, "_err"}, mem_err, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Power-on reset
    rst = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd31, 1'b0, 1'b0, 1'b0, 1'b1);
    #12;
    chk_all_zero("por");
    bubble();
    rst = 1'b0;
    step();

    // ALU pass-through
    drive(1'b1, 32'h0000_002A, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(32'd42);
    step();
    chk_wb("alu", 1'b1, 5'd3);
    chk("alu_stall", mem_stall, 1'b0);
    bubble();
    step();
    chk("alu_clear_rw", wb_rw, 1'b0);
    chk("alu_hold_data", wb_data, 32'd42);

    // Async reset away from the clock edge
    drive(1'b1, 32'h0000_0055, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("pre_rst_rw", wb_rw, 1'b1);
    drive(1'b1, 32'h0000_0099, 32'hFFFF_0000, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    bubble();
    #1;
    rst = 1'b0;
    step();

    // Store then load to the same index
    drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("sw_rw", wb_rw, 1'b0);
    chk("sw_stall", mem_stall, 1'b0);
    drive(1'b1, 32'h0000_0010, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    chk("lw_stall", mem_stall, 1'b1);
    chk("lw_early_rw", wb_rw, 1'b0);
    bubble();
    step();
    chk("lw_stall_end", mem_stall, 1'b0);
    chk_wb("lw", 1'b1, 5'd5);
    step();
    chk("lw_clear_rw", wb_rw, 1'b0);
    chk("lw_hold_data", wb_data, 32'hDEAD_BEEF);

    // Address wrap: 0x110 aliases index 0x10
    drive(1'b1, 32'h0000_0110, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h0000_0010, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(32'hCAFE_F00D);
    step();
    bubble();
    step();
    chk_wb("wrap", 1'b1, 5'd9);

    // Load to $zero
    drive(1'b1, 32'h0000_0010, 32'h0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(32'hCAFE_F00D);
    step();
    chk("lw0_stall", mem_stall, 1'b1);
    bubble();
    step();
    chk_wb("lw0", 1'b0, 5'd0);

    // ALU to $zero
    drive(1'b1, 32'h0000_0033, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(32'h0000_0033);
    step();
    chk_wb("alu0", 1'b0, 5'd0);

    // Reset during LOAD_WAIT drops the load
    drive(1'b1, 32'h0000_0010, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    chk("rl_stall", mem_stall, 1'b1);
    bubble();
    #3;
    rst = 1'b1;
    #1;
    chk("rl_rst_stall", mem_stall, 1'b0);
    chk("rl_rst_rw", wb_rw, 1'b0);
    #1;
    rst = 1'b0;
    step();
    chk("rl_no_wb_rw", wb_rw, 1'b0);
    chk("rl_no_wb_data", wb_data, 32'h0);
    chk("rl_no_stall", mem_stall, 1'b0);
    drive(1'b1, 32'h0000_0077, 32'h0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back(32'h0000_0077);
    step();
    chk_wb("rl_alu", 1'b1, 5'd12);

    // Simultaneous MemRead/MemWrite
    drive(1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("cf_pre_err", mem_err, 1'b0);
    drive(1'b1, 32'h0000_0004, 32'h0000_0001, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk("cf_rw", wb_rw, 1'b0);
    chk("cf_stall", mem_stall, 1'b0);
    chk("cf_err", mem_err, EXP_ERR);
    drive(1'b1, 32'h0000_0004, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_q.push_back(EXP_IDX4);
    step();
    chk("cf_lw_stall", mem_stall, 1'b1);
    bubble();
    step();
    chk_wb("cf_lw", 1'b1, 5'd10);
    step();
    step();
    chk("cf_err_held", mem_err, EXP_ERR);
    rst = 1'b1;
    #1;
    chk("cf_err_rst", mem_err, 1'b0);
    rst = 1'b0;
    step();

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage plus MEM/WB pipeline register of the 5-stage pipeline.
- Executes LW/SW against an internal synchronous data RAM and drives the register-file write-back port (WB_RegWrite, WB_writeReg, WB_writeData) that ID_STAGE consumes.
- A load takes two cycles, and the block raises mem_stall for the second cycle.

Parameters:
DATA_W, 32, datapath / memory word width
ADDR_W, 8, data-RAM word-index width (depth = 2**ADDR_W = 256)
REG_W, 5, register address width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
EX_MEM_Valid  input  1  EX/MEM register holds a real instruction
EX_MEM_ALUResult  input  DATA_W  address (load/store) or result (ALU op)
EX_MEM_WriteData  input  DATA_W  store data (Rt contents)
EX_MEM_Rd  input  REG_W  destination register
EX_MEM_MemRead  input  1  LW
EX_MEM_MemWrite  input  1  SW
EX_MEM_MemToReg  input  1  write-back selects memory data
EX_MEM_RegWrite  input  1  instruction writes the register file
mem_stall  output  1  upstream must hold EX/MEM contents this cycle
WB_RegWrite  output  1  register-file write enable
WB_writeReg  output  REG_W  register-file write address
WB_writeData  output  DATA_W  register-file write data
mem_err  output  1  sticky conflict flag (MEM_CONFLICT_CHECK_EN only, else tied 0)

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All WB_* outputs, mem_stall and mem_err go to 0.
  - RAM contents are not reset.
- Address: word index = EX_MEM_ALUResult[ADDR_W-1:0]. Upper bits are ignored, so the address wraps modulo 256.
- FSM states: IDLE, LOAD_WAIT.
- IDLE, EX_MEM_Valid=0:
  - WB_RegWrite is cleared at the next edge.
  - WB_writeReg and WB_writeData hold their values.
- IDLE, Valid=1, MemWrite=1, MemRead=0 (store):
  - RAM[idx] <= WriteData at this edge.
  - Next cycle WB_RegWrite=0.
  - Stays in IDLE, no stall.
- IDLE, Valid=1, MemRead=1, MemWrite=0 (load):
  - RAM is addressed this edge; go to LOAD_WAIT.
  - Rd and RegWrite are latched internally.
- LOAD_WAIT:
  - mem_stall=1 (combinational on state).
  - EX_MEM inputs are ignored.
  - At the edge: WB_writeData <= RAM read data, WB_writeReg <= latched Rd, WB_RegWrite <= latched RegWrite; return to IDLE.
  - Result is visible 2 cycles after the load is accepted.
- IDLE, Valid=1, no memory op (ALU instruction):
  - Next cycle WB_writeData = ALUResult, WB_writeReg = Rd, WB_RegWrite = RegWrite (1-cycle latency).
- Register $zero: WB_RegWrite is forced to 0 whenever the destination register is 0.
- Store then load to the same index on the next accepted instruction: the load returns the new data (the write completes before the read edge).
- MemRead=1 and MemWrite=1 together (illegal): handled per the optional feature below.
- Reset during LOAD_WAIT: the load is dropped, the state returns to IDLE and no write-back occurs.

Optional Feature:
MEM_CONFLICT_CHECK_EN
- Defined:
  - A simultaneous MemRead and MemWrite performs neither access.
  - WB_RegWrite=0 next cycle.
  - mem_err sets and stays set until rst.
- Undefined:
  - The write wins: the store is performed and the read is ignored.
  - mem_err is tied 0.

Decomposition:
- Shared package (pipeline_pkg):
  - DATA_W, ADDR_W, REG_W defaults.
  - The FSM state encoding (IDLE=0, LOAD_WAIT=1).
  - The REG_ZERO constant.
- Sub-module data_mem: single-port synchronous RAM, 2**ADDR_W x DATA_W, with a write-enable input and registered read data.

Test Plan:
- Reset: assert rst mid-cycle with arbitrary inputs -> all outputs 0 immediately, independent of clk.
- Store then load:
  - SW WriteData=32'hDEADBEEF, ALUResult=8'h10.
  - Then LW ALUResult=8'h10, Rd=5, RegWrite=1, MemToReg=1.
  - Expect mem_stall=1 for exactly 1 cycle, then WB_RegWrite=1, WB_writeReg=5, WB_writeData=32'hDEADBEEF.
- ALU pass-through: ALUResult=32'h0000002A, Rd=3, RegWrite=1 -> next cycle WB_writeData=42, WB_writeReg=3, WB_RegWrite=1, mem_stall=0.
- Wrap and $zero:
  - SW to ALUResult=32'h00000110, then LW from 32'h00000010 -> returns the stored data (wrap).
  - LW with Rd=0 -> WB_RegWrite=0.
- Reset mid-load: LW accepted, rst pulsed during LOAD_WAIT -> no WB_RegWrite pulse; the next ALU op completes normally.
- Conflict:
  - MemRead=MemWrite=1, WriteData=32'h1 to index 4.
  - With the macro: RAM[4] unchanged, mem_err=1 and held.
  - Without it: RAM[4]=1, mem_err=0.
